// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, data-memory wait.
// Latency: zero-cycle control outputs (combinational from state + inputs); mem_timeout and counters are registered.
// Backpressure: stalls PC/IF-ID/EX-MEM while a data-memory access is unacknowledged; never stalls on its own outputs.
//
// Ports: clk/rst_n (async active-low); ID operands (id_rs1/2, id_use_rs1/2);
//        EX control (ex_rd, ex_RegWEn, ex_MemEn, ex_MemRW, ex_br_taken); dmem_req/dmem_ack handshake.
//        Outputs: pc_stall, if_id_stall, if_id_clr, id_reg_clr, ex_mem_stall, mem_timeout, stall_cnt, flush_cnt.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_RegWEn,
    input  logic             ex_MemEn,
    input  logic             ex_MemRW,
    input  logic             ex_br_taken,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_clr,
    output logic             id_reg_clr,
    output logic             ex_mem_stall,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, MEM_WAIT = 2'd2} state_e;

    localparam logic [3:0]       FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
    localparam logic [15:0]      TIMEOUT    = 16'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_e           state_q, state_d;
    logic [3:0]       fcnt_q, fcnt_d;     // FLUSH cycles still to run after the current one
    logic [15:0]      wcnt_q, wcnt_d;     // unacknowledged wait cycles, saturates at TIMEOUT
    logic             mto_q, mto_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic lu_hit, mem_miss, br_accept;
    logic pc_stall_c, if_id_stall_c, if_id_clr_c, id_reg_clr_c, ex_mem_stall_c;

    assign lu_hit = ex_MemEn & ~ex_MemRW & ex_RegWEn & (ex_rd != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    assign mem_miss = dmem_req & ~dmem_ack;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            fcnt_q      <= 4'd0;
            wcnt_q      <= 16'd0;
            mto_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            wcnt_q      <= wcnt_d;
            mto_q       <= mto_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        wcnt_d    = wcnt_q;
        mto_d     = mto_q;
        br_accept = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_miss) begin
                    state_d = MEM_WAIT;
                    wcnt_d  = 16'd1;            // the entry cycle is the first wait cycle
                end else if (ex_br_taken) begin
                    br_accept = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        fcnt_d  = FLUSH_INIT;
                    end
                end
            end
            FLUSH: begin
                // Branches seen here are wrong-path and ignored.
                fcnt_d = fcnt_q - 4'd1;
                if (fcnt_d == 4'd0) state_d = RUN;
            end
            MEM_WAIT: begin
                if (dmem_ack) state_d = RUN;
                else if (wcnt_q < TIMEOUT) wcnt_d = wcnt_q + 16'd1;
            end
            default: state_d = RUN;
        endcase
        // Sticky: the FSM keeps waiting; the flag just reports the overrun.
        if (state_d == MEM_WAIT && wcnt_d >= TIMEOUT) mto_d = 1'b1;

        stall_cnt_d = stall_cnt_q;
        if (pc_stall_c && stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_ONE;
        flush_cnt_d = flush_cnt_q;
        if (br_accept && flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_ONE;
    end

    // Output decode: priority mem wait > branch flush > load-use
    always_comb begin
        pc_stall_c     = 1'b0;
        if_id_stall_c  = 1'b0;
        if_id_clr_c    = 1'b0;
        id_reg_clr_c   = 1'b0;
        ex_mem_stall_c = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_miss) begin
                    pc_stall_c     = 1'b1;
                    if_id_stall_c  = 1'b1;
                    ex_mem_stall_c = 1'b1;
                end else if (ex_br_taken) begin
                    if_id_clr_c  = 1'b1;
                    id_reg_clr_c = 1'b1;
                end else if (lu_hit) begin
                    // One bubble suffices: next cycle the load has left EX.
                    pc_stall_c    = 1'b1;
                    if_id_stall_c = 1'b1;
                    id_reg_clr_c  = 1'b1;
                end
            end
            FLUSH: begin
                if_id_clr_c  = 1'b1;
                id_reg_clr_c = 1'b1;
            end
            MEM_WAIT: begin
                // ID/EX holds through the stall, so no bubble; stalls drop in the ack cycle.
                if (!dmem_ack) begin
                    pc_stall_c     = 1'b1;
                    if_id_stall_c  = 1'b1;
                    ex_mem_stall_c = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Combinational outputs are forced low while reset is held, regardless of inputs.
    assign pc_stall     = pc_stall_c     & rst_n;
    assign if_id_stall  = if_id_stall_c  & rst_n;
    assign if_id_clr    = if_id_clr_c    & rst_n;
    assign id_reg_clr   = id_reg_clr_c   & rst_n;
    assign ex_mem_stall = ex_mem_stall_c & rst_n;
    assign mem_timeout  = mto_q;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: two instances (default and small-counter/short-timeout) on shared stimulus.
// Latency: expected outputs pushed per cycle when inputs are driven, popped and compared mid-cycle.
// Backpressure: none; stimulus is a fixed directed sequence.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       id_use_rs1 = 0, id_use_rs2 = 0, ex_RegWEn = 0, ex_MemEn = 0, ex_MemRW = 0;
    logic       ex_br_taken = 0, dmem_req = 0, dmem_ack = 0;

    logic        a_pc, a_ifs, a_ifc, a_idc, a_exm, a_mto;
    logic [31:0] a_sc, a_fc;
    logic        b_pc, b_ifs, b_ifc, b_idc, b_exm, b_mto;
    logic [3:0]  b_sc, b_fc;

    always #5 clk = ~clk;

    hazard_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_RegWEn(ex_RegWEn), .ex_MemEn(ex_MemEn), .ex_MemRW(ex_MemRW),
        .ex_br_taken(ex_br_taken), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .pc_stall(a_pc), .if_id_stall(a_ifs), .if_id_clr(a_ifc), .id_reg_clr(a_idc),
        .ex_mem_stall(a_exm), .mem_timeout(a_mto), .stall_cnt(a_sc), .flush_cnt(a_fc)
    );

    hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(4), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_RegWEn(ex_RegWEn), .ex_MemEn(ex_MemEn), .ex_MemRW(ex_MemRW),
        .ex_br_taken(ex_br_taken), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .pc_stall(b_pc), .if_id_stall(b_ifs), .if_id_clr(b_ifc), .id_reg_clr(b_idc),
        .ex_mem_stall(b_exm), .mem_timeout(b_mto), .stall_cnt(b_sc), .flush_cnt(b_fc)
    );

    typedef struct {
        logic        pc, ifs, ifc, idc, exm, mto;
        logic [31:0] sc, fc;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // Reference model state, index 0 = dut_a, 1 = dut_b
    int          p_mt[2]  = '{255, 4};
    int          p_w[2]   = '{32, 4};
    int          m_st[2], m_f[2], m_w[2], n_st[2], n_f[2], n_w[2];
    bit          m_mto[2], n_mto[2];
    longint      m_sc[2], m_fc[2], n_sc[2], n_fc[2];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_f[k] = 0; m_w[k] = 0; m_mto[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
        end
    endtask

    // Expected outputs for the current inputs; next state staged in n_*.
    task automatic model_push();
        bit lu, miss;
        longint mx;
        exp_t e;
        lu = ex_MemEn && !ex_MemRW && ex_RegWEn && ex_rd != 0 &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        miss = dmem_req && !dmem_ack;
        for (int k = 0; k < 2; k++) begin
            mx = (64'sd1 <<< p_w[k]) - 1;
            e = '{0, 0, 0, 0, 0, m_mto[k], 32'(m_sc[k]), 32'(m_fc[k])};
            n_st[k] = m_st[k]; n_f[k] = m_f[k]; n_w[k] = m_w[k];
            n_mto[k] = m_mto[k]; n_sc[k] = m_sc[k]; n_fc[k] = m_fc[k];
            if (m_st[k] == 0) begin
                if (miss) begin
                    e.pc = 1; e.ifs = 1; e.exm = 1; n_st[k] = 2; n_w[k] = 1;
                end else if (ex_br_taken) begin
                    e.ifc = 1; e.idc = 1; n_st[k] = 1; n_f[k] = 1;
                    if (m_fc[k] < mx) n_fc[k] = m_fc[k] + 1;
                end else if (lu) begin
                    e.pc = 1; e.ifs = 1; e.idc = 1;
                end
            end else if (m_st[k] == 1) begin
                e.ifc = 1; e.idc = 1;
                n_f[k] = m_f[k] - 1;
                if (n_f[k] == 0) n_st[k] = 0;
            end else begin
                if (dmem_ack) n_st[k] = 0;
                else begin
                    e.pc = 1; e.ifs = 1; e.exm = 1;
                    if (m_w[k] < p_mt[k]) n_w[k] = m_w[k] + 1;
                end
            end
            if (n_st[k] == 2 && n_w[k] >= p_mt[k]) n_mto[k] = 1;
            if (e.pc && m_sc[k] < mx) n_sc[k] = m_sc[k] + 1;
            sbq.push_back(e);
        end
    endtask

    task automatic pop_compare();
        exp_t e;
        e = sbq.pop_front();
        check("A.pc_stall", 32'(a_pc), 32'(e.pc));
        check("A.if_id_stall", 32'(a_ifs), 32'(e.ifs));
        check("A.if_id_clr", 32'(a_ifc), 32'(e.ifc));
        check("A.id_reg_clr", 32'(a_idc), 32'(e.idc));
        check("A.ex_mem_stall", 32'(a_exm), 32'(e.exm));
        check("A.mem_timeout", 32'(a_mto), 32'(e.mto));
        check("A.stall_cnt", a_sc, e.sc);
        check("A.flush_cnt", a_fc, e.fc);
        e = sbq.pop_front();
        check("B.pc_stall", 32'(b_pc), 32'(e.pc));
        check("B.if_id_stall", 32'(b_ifs), 32'(e.ifs));
        check("B.if_id_clr", 32'(b_ifc), 32'(e.ifc));
        check("B.id_reg_clr", 32'(b_idc), 32'(e.idc));
        check("B.ex_mem_stall", 32'(b_exm), 32'(e.exm));
        check("B.mem_timeout", 32'(b_mto), 32'(e.mto));
        check("B.stall_cnt", 32'(b_sc), e.sc);
        check("B.flush_cnt", 32'(b_fc), e.fc);
    endtask

    // Called just after a rising edge: drive inputs, push expectations, compare mid-cycle, advance.
    task automatic cyc(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                       input logic [4:0] rd, input logic rwe, input logic men, input logic mrw,
                       input logic br, input logic req, input logic ack);
        id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        ex_rd = rd; ex_RegWEn = rwe; ex_MemEn = men; ex_MemRW = mrw;
        ex_br_taken = br; dmem_req = req; dmem_ack = ack;
        model_push();
        #4;
        pop_compare();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = n_st[k]; m_f[k] = n_f[k]; m_w[k] = n_w[k];
            m_mto[k] = n_mto[k]; m_sc[k] = n_sc[k]; m_fc[k] = n_fc[k];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Async reset applied mid-cycle with whatever inputs are currently driven.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, ".pc_stall"}, 32'(a_pc | b_pc), 32'd0);
        check({tag, ".clears"}, 32'(a_ifc | a_idc | b_ifc | b_idc), 32'd0);
        check({tag, ".stalls"}, 32'(a_ifs | a_exm | b_ifs | b_exm), 32'd0);
        check({tag, ".mem_timeout"}, 32'(a_mto | b_mto), 32'd0);
        check({tag, ".counters"}, a_sc | a_fc | 32'(b_sc) | 32'(b_fc), 32'd0);
        model_reset();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // checked with rst_n low too
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        do_reset("rst0");
        idle();

        // 1: load-use on rs1 then rs2; one bubble each, then load leaves EX
        cyc(5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0);
        cyc(5, 0, 1, 0, 6, 1, 0, 0, 0, 0, 0);
        check("t1.stall_cnt", a_sc, 32'd1);
        cyc(0, 7, 0, 1, 7, 1, 1, 0, 0, 0, 0);
        idle();
        check("t1b.stall_cnt", a_sc, 32'd2);

        // 2: non-hazards: rd=0, store, no RegWEn, operand not used
        cyc(0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0);
        cyc(5, 0, 1, 0, 5, 1, 1, 1, 0, 0, 0);
        cyc(5, 0, 1, 0, 5, 0, 1, 0, 0, 0, 0);
        cyc(5, 5, 0, 0, 5, 1, 1, 0, 0, 0, 0);
        check("t2.stall_cnt", a_sc, 32'd2);

        // 3: branch, second pulse during flush ignored
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle();
        check("t3.flush_cnt", a_fc, 32'd1);
        idle();

        // 4: memory wait of 5 cycles with branch and load-use masked
        cyc(3, 0, 1, 0, 3, 1, 1, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) cyc(3, 0, 1, 0, 3, 1, 1, 0, 1, 1, 0);
        cyc(3, 0, 1, 0, 3, 1, 1, 0, 1, 1, 1);
        check("t4.stall_cnt", a_sc, 32'd7);
        check("t4.flush_cnt", a_fc, 32'd1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);  // req with ack same cycle: no wait
        idle();

        // 5: timeout on dut_b (MEM_TIMEOUT=4), sticky past the ack
        do_reset("rst1");
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        check("t5.mto_early", 32'(b_mto), 32'd0);
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle();
        check("t5.mto_b", 32'(b_mto), 32'd1);
        check("t5.mto_a", 32'(a_mto), 32'd0);

        // 6: reset inside FLUSH and inside MEM_WAIT, inputs still active
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        ex_br_taken = 1'b1; dmem_req = 1'b1;
        do_reset("rst_flush");
        idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        id_rs1 = 5'd5; id_use_rs1 = 1'b1; ex_rd = 5'd5; ex_RegWEn = 1'b1; ex_MemEn = 1'b1;
        do_reset("rst_wait");
        idle();

        // Saturation: 20 load-use stalls and 20 accepted branches
        for (int i = 0; i < 20; i++) cyc(9, 0, 1, 0, 9, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
            idle();
        end
        idle();
        check("sat.stall_a", a_sc, 32'd20);
        check("sat.stall_b", 32'(b_sc), 32'd15);
        check("sat.flush_a", a_fc, 32'd20);
        check("sat.flush_b", 32'(b_fc), 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
